// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : two-port round-robin arbiter onto a single memory bus
// Revision        : 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int              c_cnt_w    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_port;
  logic                r_next_port;
  logic [c_cnt_w-1:0]  r_rd_cnt;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_gnt_valid;
  logic                w_gnt_port;
  logic                w_gnt_we;
  logic                w_grant;
  logic                w_rd_last;

  // r_next_port only breaks ties; a sole requester always wins.
  assign w_gnt_valid = req0 | req1;
  assign w_gnt_port  = req1 & (~req0 | r_next_port);
  assign w_gnt_we    = w_gnt_port ? we1 : we0;
  assign w_grant     = (r_state == IDLE) & w_gnt_valid;
  assign w_rd_last   = (r_state == READ) & (r_rd_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt = w_gnt_we ? WRITE : READ;
        end
      end
      WRITE:   w_state_nxt = IDLE;
      READ: begin
        if (w_rd_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port      <= 1'b0;
      r_next_port <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else if (w_grant) begin
      r_port      <= w_gnt_port;
      r_next_port <= ~w_gnt_port;
      mem_addr    <= w_gnt_port ? addr1 : addr0;
      mem_wr_data <= w_gnt_port ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
    end else if ((r_state == READ) && !w_rd_last) begin
      r_rd_cnt <= r_rd_cnt + c_cnt_w'(1);
    end else begin
      r_rd_cnt <= '0;
    end
  end

  // The bus is captured on the edge that closes the final READ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_rd_last) begin
      if (r_port) begin
        r_rdata1 <= mem_rd_data;
      end else begin
        r_rdata0 <= mem_rd_data;
      end
    end
  end

  assign mem_wr = (r_state == WRITE);
  assign mem_rd = (r_state == READ);
  assign ack0   = ((r_state == WRITE) || (r_state == DONE)) && !r_port;
  assign ack1   = ((r_state == WRITE) || (r_state == DONE)) &&  r_port;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter : directed vectors and corner sequences for mem_bus_arbiter
// Revision           : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance a: RD_LATENCY = 1
  logic        a_req0, a_we0, a_req1, a_we1, a_ack0, a_ack1, a_mem_rd, a_mem_wr;
  logic [15:0] a_addr0, a_wdata0, a_addr1, a_wdata1, a_rdata0, a_rdata1;
  logic [15:0] a_mem_addr, a_mem_wr_data, a_mem_rd_data;
  // Instance b: RD_LATENCY = 3
  logic        b_req0, b_we0, b_req1, b_we1, b_ack0, b_ack1, b_mem_rd, b_mem_wr;
  logic [15:0] b_addr0, b_wdata0, b_addr1, b_wdata1, b_rdata0, b_rdata1;
  logic [15:0] b_mem_addr, b_mem_wr_data, b_mem_rd_data;

  mem_bus_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0), .ack0(a_ack0), .rdata0(a_rdata0),
    .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1), .ack1(a_ack1), .rdata1(a_rdata1),
    .mem_addr(a_mem_addr), .mem_wr_data(a_mem_wr_data), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
    .mem_rd_data(a_mem_rd_data)
  );

  mem_bus_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
    .mem_addr(b_mem_addr), .mem_wr_data(b_mem_wr_data), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .mem_rd_data(b_mem_rd_data)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe and ack exclusivity, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(a_mem_rd && a_mem_wr)) else begin checks++; $display("FAIL a_rd_wr_overlap: got 1 expected 0"); end
      assert (!(a_ack0 && a_ack1))     else begin checks++; $display("FAIL a_ack_overlap: got 1 expected 0"); end
      assert (!(b_mem_rd && b_mem_wr)) else begin checks++; $display("FAIL b_rd_wr_overlap: got 1 expected 0"); end
      assert (!(b_ack0 && b_ack1))     else begin checks++; $display("FAIL b_ack_overlap: got 1 expected 0"); end
    end
  end

  typedef struct {
    logic        req0;
    logic        we0;
    logic [15:0] addr0;
    logic [15:0] wdata0;
    logic        req1;
    logic        we1;
    logic [15:0] addr1;
    logic [15:0] wdata1;
    logic [15:0] bus;
    logic        exp_port;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] model_rd0, model_rd1;

  task automatic idle_inputs();
    a_req0 = 0; a_we0 = 0; a_addr0 = '0; a_wdata0 = '0;
    a_req1 = 0; a_we1 = 0; a_addr1 = '0; a_wdata1 = '0; a_mem_rd_data = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0; b_mem_rd_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    a_req0 = v.req0; a_we0 = v.we0; a_addr0 = v.addr0; a_wdata0 = v.wdata0;
    a_req1 = v.req1; a_we1 = v.we1; a_addr1 = v.addr1; a_wdata1 = v.wdata1;
    a_mem_rd_data = v.bus;
    tick();
    chk($sformatf("v%0d mem_addr", i), a_mem_addr, v.exp_addr);
    if (v.exp_we) begin
      chk($sformatf("v%0d mem_wr", i), a_mem_wr, 1'b1);
      chk($sformatf("v%0d mem_wr_data", i), a_mem_wr_data, v.exp_data);
      chk($sformatf("v%0d ack0", i), a_ack0, v.exp_port == 1'b0);
      chk($sformatf("v%0d ack1", i), a_ack1, v.exp_port == 1'b1);
    end else begin
      chk($sformatf("v%0d mem_rd", i), a_mem_rd, 1'b1);
      chk($sformatf("v%0d early_ack", i), a_ack0 | a_ack1, 1'b0);
      tick();
      chk($sformatf("v%0d done_mem_rd", i), a_mem_rd, 1'b0);
      chk($sformatf("v%0d ack0", i), a_ack0, v.exp_port == 1'b0);
      chk($sformatf("v%0d ack1", i), a_ack1, v.exp_port == 1'b1);
      if (v.exp_port) model_rd1 = v.exp_data;
      else            model_rd0 = v.exp_data;
      chk($sformatf("v%0d rdata", i), v.exp_port ? a_rdata1 : a_rdata0, v.exp_data);
    end
    a_req0 = 0; a_req1 = 0;
    tick();
    chk($sformatf("v%0d idle_ack", i), {a_ack0, a_ack1, a_mem_rd, a_mem_wr}, 4'b0000);
    chk($sformatf("v%0d idle_addr_hold", i), a_mem_addr, v.exp_addr);
    chk($sformatf("v%0d rdata0_hold", i), a_rdata0, model_rd0);
    chk($sformatf("v%0d rdata1_hold", i), a_rdata1, model_rd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    int   rd_cycles;
    int   ack_at;
    logic order[4];
    logic [15:0] got;

    //          req0 we0  addr0     wdata0    req1 we1  addr1     wdata1    bus       port we   exp_addr  exp_data
    vecs[0] = '{1'b1,1'b1,16'h0010,16'hBEEF, 1'b0,1'b0,16'h0000,16'h0000, 16'h0000, 1'b0,1'b1,16'h0010,16'hBEEF};
    vecs[1] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0010,16'h0000, 16'hBEEF, 1'b1,1'b0,16'h0010,16'hBEEF};
    vecs[2] = '{1'b1,1'b1,16'h0020,16'h1234, 1'b1,1'b0,16'h0030,16'h0000, 16'h4444, 1'b0,1'b1,16'h0020,16'h1234};
    vecs[3] = '{1'b1,1'b0,16'h0040,16'h0000, 1'b1,1'b1,16'h0050,16'h5678, 16'h4444, 1'b1,1'b1,16'h0050,16'h5678};
    vecs[4] = '{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h0060,16'h0000, 16'hCAFE, 1'b1,1'b0,16'h0060,16'hCAFE};
    vecs[5] = '{1'b1,1'b0,16'h0070,16'h0000, 1'b1,1'b1,16'h0071,16'h1111, 16'hA5A5, 1'b0,1'b0,16'h0070,16'hA5A5};
    vecs[6] = '{1'b1,1'b1,16'h0080,16'h0F0F, 1'b0,1'b0,16'h0000,16'h0000, 16'h0000, 1'b0,1'b1,16'h0080,16'h0F0F};
    vecs[7] = '{1'b1,1'b1,16'h00F0,16'h2222, 1'b1,1'b0,16'h0090,16'h0000, 16'h1357, 1'b1,1'b0,16'h0090,16'h1357};

    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    // Before any clock edge: asynchronous reset values
    chk("rst_strobes", {a_mem_rd, a_mem_wr, a_ack0, a_ack1}, 4'b0000);
    chk("rst_mem_addr", a_mem_addr, 16'h0000);
    chk("rst_mem_wr_data", a_mem_wr_data, 16'h0000);
    chk("rst_rdata", {a_rdata0, a_rdata1}, 32'h0);
    tick();
    rst_n = 1'b1;
    model_rd0 = '0;
    model_rd1 = '0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Contention: both writers held continuously from reset
    do_reset();
    a_req0 = 1; a_we0 = 1; a_addr0 = 16'h0100; a_wdata0 = 16'h1111;
    a_req1 = 1; a_we1 = 1; a_addr1 = 16'h0200; a_wdata1 = 16'h2222;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      tick();
      if (a_ack0 || a_ack1) begin
        order[n] = a_ack1;
        chk($sformatf("cont%0d mem_addr", n), a_mem_addr, a_ack1 ? 16'h0200 : 16'h0100);
        n++;
      end
    end
    chk("cont_grants_seen", n, 4);
    for (int k = 0; k < n; k++) chk($sformatf("cont_order%0d", k), order[k], k[0]);
    a_req0 = 0; a_req1 = 0;

    // Read latency sweep on RD_LATENCY=3
    do_reset();
    b_req0 = 1; b_we0 = 0; b_addr0 = 16'h00A5; b_mem_rd_data = 16'h1000;
    tick();
    rd_cycles = 0; ack_at = 0; got = '0;
    for (int k = 1; k <= 8; k++) begin
      if (b_mem_rd) begin
        rd_cycles++;
        chk($sformatf("sweep_addr%0d", k), b_mem_addr, 16'h00A5);
      end
      if (b_ack0 && ack_at == 0) begin
        ack_at = k;
        got = b_rdata0;
        chk("sweep_rd_low_at_ack", b_mem_rd, 1'b0);
        b_req0 = 0;
      end
      b_mem_rd_data = 16'h1000 + 16'(k);
      tick();
    end
    chk("sweep_rd_cycles", rd_cycles, 3);
    chk("sweep_ack_latency", ack_at, 4);
    chk("sweep_rdata", got, 16'h1003);

    // Reset in the 2nd READ cycle, then a fresh read from port 1
    b_req1 = 1; b_we1 = 0; b_addr1 = 16'h0033; b_mem_rd_data = 16'hD00D;
    tick();
    tick();
    chk("midrst_in_read", b_mem_rd, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_async_drop", {b_mem_rd, b_ack0, b_ack1}, 3'b000);
    chk("midrst_rdata0_clr", b_rdata0, 16'h0000);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("midrst_no_ack%0d", k), {b_ack0, b_ack1, b_mem_rd}, 3'b000);
    end
    rst_n = 1'b1;
    ack_at = 0; got = '0;
    for (int k = 1; k <= 12 && ack_at == 0; k++) begin
      tick();
      chk($sformatf("midrst_ack0_%0d", k), b_ack0, 1'b0);
      if (b_ack1) begin
        ack_at = k;
        got = b_rdata1;
        b_req1 = 0;
      end
    end
    chk("midrst_ack_latency", ack_at, 4);
    chk("midrst_rdata1", got, 16'hD00D);
    tick();
    chk("midrst_idle", {b_ack0, b_ack1, b_mem_rd, b_mem_wr}, 4'b0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, memory data width; ADDR_W, default 16, memory address width; RD_LATENCY, default 1, legal range 1-8, clock cycles mem_rd is held before read data is sampled.
REQ-002 Ports (clock and reset first):
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
REQ-003 Requester ports, n in {0,1}:
- reqN  input  1  transaction request, held until ackN.
- weN  input  1  1 = write, 0 = read.
- addrN  input  ADDR_W  transaction address.
- wdataN  input  DATA_W  write data.
- ackN  output  1  one-cycle completion pulse.
- rdataN  output  DATA_W  read data, valid while ackN=1 for a read.
REQ-004 Memory-side ports:
- mem_addr  output  ADDR_W  memory address.
- mem_wr_data  output  DATA_W  write data; the memory interface drives this onto the shared data bus while mem_wr=1.
- mem_rd  output  1  read strobe.
- mem_wr  output  1  write strobe.
- mem_rd_data  input  DATA_W  data bus as seen by the memory interface.
REQ-005 The block SHALL have one clock and one reset; rst_n SHALL be asynchronous and active-low.

Function
REQ-006 The FSM SHALL have states IDLE, WRITE, READ and DONE; all outputs SHALL be registered or decoded only from registered state.
REQ-007 IDLE: if any reqN=1, the arbiter SHALL select a winner, latch the winner's addr, wdata, we and port ID, then go to WRITE if we=1, else to READ.
REQ-008 Arbitration SHALL be round-robin: a sole requester wins; if both request, the port not granted last wins; after reset, port 0 is treated as the next to win.
REQ-009 The last-granted pointer SHALL update only on entry to WRITE or READ.
REQ-010 WRITE SHALL last exactly 1 cycle:
- mem_wr=1, mem_addr and mem_wr_data = latched values.
- ack of the winner = 1 in that same cycle.
- next state IDLE.
REQ-011 READ SHALL last exactly RD_LATENCY cycles with mem_rd=1 and mem_addr = latched address.
REQ-012 A cycle counter SHALL be used in READ; mem_rd_data SHALL be captured at the clock edge ending the last READ cycle; next state DONE.
REQ-013 DONE SHALL last 1 cycle:
- mem_rd=0.
- winner's ack = 1 and its rdata = captured word.
- next state IDLE.
REQ-014 Requests arriving outside IDLE SHALL be ignored until the FSM returns to IDLE; no request is lost while reqN is held.
REQ-015 mem_rd and mem_wr SHALL never be 1 in the same cycle.
REQ-016 ack0 and ack1 SHALL never be 1 in the same cycle.
REQ-017 ackN SHALL never assert for a port that did not win the current transaction.
REQ-018 rdataN SHALL hold its last captured value until the next read completes for that port.
REQ-019 Writes SHALL leave rdataN unchanged.
REQ-020 mem_addr and mem_wr_data SHALL hold their last values in IDLE.
REQ-021 Latency SHALL be:
- write: req sampled in IDLE -> ack 1 cycle later (2 cycles per transaction).
- read: req sampled in IDLE -> ack RD_LATENCY+1 cycles later (RD_LATENCY+2 cycles per transaction).
REQ-022 Deasserting reqN before ackN SHALL be a protocol violation; the latched transaction SHALL still complete.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force:
- state = IDLE.
- mem_rd, mem_wr, ack0, ack1 = 0.
- mem_addr, mem_wr_data, rdata0, rdata1 = 0.
- round-robin pointer = port 0 next.
- read counter = 0.
REQ-024 Reset during WRITE, READ or DONE SHALL abort the transaction with no ack; the requester must re-request.
REQ-025 After rst_n deasserts, the first request SHALL be sampled on the first rising edge with rst_n=1.

Verification
REQ-026 Single write: req0=1, we0=1, addr0=16'h0010, wdata0=16'hBEEF -> next cycle mem_wr=1, mem_addr=16'h0010, mem_wr_data=16'hBEEF, ack0=1; following cycle mem_wr=0, state IDLE.
REQ-027 Single read, RD_LATENCY=1: req1=1, we1=0, addr1=16'h0010, memory returns 16'hBEEF -> mem_rd=1 for 1 cycle; next cycle ack1=1, rdata1=16'hBEEF, mem_rd=0.
REQ-028 Contention: both requests held continuously from reset -> grant order 0,1,0,1; ack0 and ack1 never coincide.
REQ-029 Read latency sweep, RD_LATENCY=3: read of addr 16'h00A5 -> mem_rd high exactly 3 cycles; ack 4 cycles after request sampled; rdata equals the bus value on the final READ edge.
REQ-030 Reset mid-read: assert rst_n=0 in the 2nd READ cycle -> mem_rd drops without a clock edge; no ack; after release, a fresh read from port 1 completes normally.
REQ-031 Every scenario SHALL check by assertion: never mem_rd and mem_wr both 1; never ack0 and ack1 both 1.
